mc_controller: RTL and testbench
================================

# mc_controller

Multi-cycle control FSM for the 32-bit MIPS datapath. Decodes the instruction held in IR (`instt`) and sequences the datapath one state per clock. It drives every datapath select and enable (`PCsig`, `lord`, `IRwrite`, `reg_write`, `reg_dst`, `mem_to_reg`, `alu_srca`, `alu_srcb`, `alu_ctrl`, `pc_src`) plus the memory read/write strobes. It sits beside `datapath` and closes the loop through the `zero` flag.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `instt`  in  32  IR contents; uses [31:26] opcode and [5:0] funct
- `zero`  in  1  ALU zero flag, combinational from datapath
- `PCsig`  out  1  PC write enable
- `lord`  out  1  memory address select: 0 = PC, 1 = ALU_out register
- `IRwrite`  out  1  IR load enable
- `reg_write`  out  1  register file write enable
- `alu_srca`  out  1  0 = PC, 1 = A
- `alu_srcb`  out  2  0 = B, 1 = 4, 2 = sign-extended imm, 3 = sign-extended imm<<2
- `alu_ctrl`  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- `reg_dst`  out  2  0 = rt, 1 = rd, 2 = r31
- `mem_to_reg`  out  2  0 = ALU_out, 1 = MDR, 2 = PC
- `pc_src`  out  2  0 = ALU result, 1 = jump target, 2 = ALU_out register, 3 = A
- `mem_read`  out  1  memory read strobe
- `mem_write`  out  1  memory write strobe
- `state`  out  4  current state encoding, for debug
- `illegal`  out  1  high for one cycle on an undecodable instruction

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BEQ=8, IEXEC=9, IWB=10, JUMP=11, JAL=12, JR=13, ILL=14.
- Outputs are Moore-decoded from `state`. The one exception is `PCsig` in BEQ, which equals `zero`.
- Every output not listed for a state is 0.
- FETCH: `mem_read`=1, `lord`=0, `IRwrite`=1, `alu_srca`=0, `alu_srcb`=1, `alu_ctrl`=ADD, `pc_src`=0, `PCsig`=1. Next state DECODE.
- DECODE: `alu_srca`=0, `alu_srcb`=3, ADD, so ALU_out = branch target. Next state by opcode/funct:
  - lw 100011 or sw 101011 → MEMADR
  - R-type 000000 with a legal funct → REXEC
  - funct 001000 → JR
  - beq 000100 → BEQ
  - addi 001000 → IEXEC
  - j 000010 → JUMP
  - jal 000011 → JAL
  - anything else → ILL
- MEMADR: `alu_srca`=1, `alu_srcb`=2, ADD. Next MEMRD for lw, MEMWR for sw.
- MEMRD: `mem_read`=1, `lord`=1. Next MEMWB.
- MEMWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Next FETCH.
- MEMWR: `mem_write`=1, `lord`=1. Next FETCH.
- REXEC: `alu_srca`=1, `alu_srcb`=0, `alu_ctrl` from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT. Next RWB.
- RWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Next FETCH.
- BEQ: `alu_srca`=1, `alu_srcb`=0, SUB, `pc_src`=2, `PCsig`=`zero`. Next FETCH.
- IEXEC: `alu_srca`=1, `alu_srcb`=2, ADD. Next IWB.
- IWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Next FETCH.
- JUMP: `pc_src`=1, `PCsig`=1. Next FETCH.
- JAL: `reg_write`=1, `reg_dst`=2, `mem_to_reg`=2, `pc_src`=1, `PCsig`=1. r31 receives the pre-edge PC, which is already PC+4. Next FETCH.
- JR: `pc_src`=3, `PCsig`=1. Next FETCH.
- ILL: `illegal`=1, all enables 0. Next FETCH. The PC has already advanced, so the bad instruction is skipped.

## Timing
- Reset: while `rst`=1, `state`←FETCH at each edge and all outputs are forced to 0, including `PCsig` and `IRwrite`. The first FETCH is on the first cycle with `rst`=0.
- `rst` asserted mid-instruction aborts it at the next edge with no further writes. Partial effects already committed (PC+4, IR) persist.
- Cycle counts, FETCH to FETCH:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j, jal, jr, illegal: 3
- `instt` is sampled only in DECODE, MEMADR and REXEC. It is stable there because IR loads only in FETCH.
- `zero` → `PCsig` is the only combinational input-to-output path.
- Every state occupies exactly one cycle; there are no stalls or memory wait states.
- Unused encoding 15 → FETCH with all outputs 0.

## Configuration
- `MC_CTRL_JAL_JR_EN` defined:
  - JAL and JR states exist.
  - `reg_dst`=2, `mem_to_reg`=2 and `pc_src`=3 are reachable.
- Undefined:
  - opcode 000011 and R-type funct 001000 decode to ILL.
  - `reg_dst` and `mem_to_reg` never exceed 1.
  - `pc_src` never equals 3.

## Test plan
- Reset held 3 cycles, then released → `state`=0 and all outputs 0 during reset. Cycle 1 after release: `IRwrite`=1, `PCsig`=1, `alu_srcb`=1, `alu_ctrl`=010.
- lw, `instt`=0x8C220004 → states 0,1,2,3,4,0. MEMRD has `lord`=1, `mem_read`=1. MEMWB has `reg_write`=1, `mem_to_reg`=1.
- sw 0xAC220004 → states 0,1,2,5,0. `mem_write`=1 for exactly one cycle.
- beq 0x10220003:
  - `zero`=1 in BEQ → `PCsig`=1, `pc_src`=2.
  - `zero`=0 → `PCsig`=0.
  - Either way, 3 cycles.
- R-type slt 0x0022182A → REXEC `alu_ctrl`=111, RWB `reg_dst`=1.
- Opcode 0x3F → ILL, `illegal`=1 for one cycle, back to FETCH. Rerun jal 0x0C000010 in both macro builds:
  - macro defined → JAL, `reg_dst`=2, `PCsig`=1.
  - macro undefined → ILL.

Source files
------------

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle MIPS control FSM, one state per clock.
// Optional JAL/JR support is enabled by defining MC_CTRL_JAL_JR_EN.
module mc_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instt,
    input  logic        zero,
    output logic        PCsig,
    output logic        lord,
    output logic        IRwrite,
    output logic        reg_write,
    output logic        alu_srca,
    output logic [1:0]  alu_srcb,
    output logic [2:0]  alu_ctrl,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic [1:0]  pc_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  state,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13,
        S_ILL    = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     r_state;
    state_t     w_next;
    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_funct_alu;
    logic       w_unused_bits;

    assign w_op          = instt[31:26];
    assign w_funct       = instt[5:0];
    assign w_unused_bits = ^instt[25:6];

    assign w_funct_alu = (w_funct == FN_ADD) || (w_funct == FN_SUB) ||
                         (w_funct == FN_AND) || (w_funct == FN_OR)  ||
                         (w_funct == FN_SLT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE: begin
                        if (w_funct_alu) begin
                            w_next = S_REXEC;
`ifdef MC_CTRL_JAL_JR_EN
                        end else if (w_funct == FN_JR) begin
                            w_next = S_JR;
`endif
                        end else begin
                            w_next = S_ILL;
                        end
                    end
                    OP_BEQ:  w_next = S_BEQ;
                    OP_ADDI: w_next = S_IEXEC;
                    OP_J:    w_next = S_JUMP;
`ifdef MC_CTRL_JAL_JR_EN
                    OP_JAL:  w_next = S_JAL;
`endif
                    default: w_next = S_ILL;
                endcase
            end
            S_MEMADR: w_next = (w_op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            S_REXEC:  w_next = S_RWB;
            S_IEXEC:  w_next = S_IWB;
            default:  w_next = S_FETCH;
        endcase
    end

    // Moore decode; reset overrides everything so no enable leaks while rst is high
    always_comb begin
        PCsig      = 1'b0;
        lord       = 1'b0;
        IRwrite    = 1'b0;
        reg_write  = 1'b0;
        alu_srca   = 1'b0;
        alu_srcb   = 2'd0;
        alu_ctrl   = 3'b000;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        pc_src     = 2'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        state      = 4'd0;
        illegal    = 1'b0;
        if (!rst) begin
            state = r_state;
            case (r_state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    IRwrite  = 1'b1;
                    alu_srcb = 2'd1;
                    alu_ctrl = ALU_ADD;
                    PCsig    = 1'b1;
                end
                S_DECODE: begin
                    alu_srcb = 2'd3;
                    alu_ctrl = ALU_ADD;
                end
                S_MEMADR, S_IEXEC: begin
                    alu_srca = 1'b1;
                    alu_srcb = 2'd2;
                    alu_ctrl = ALU_ADD;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    lord     = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'd1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    lord      = 1'b1;
                end
                S_REXEC: begin
                    alu_srca = 1'b1;
                    case (w_funct)
                        FN_SUB:  alu_ctrl = ALU_SUB;
                        FN_AND:  alu_ctrl = ALU_AND;
                        FN_OR:   alu_ctrl = ALU_OR;
                        FN_SLT:  alu_ctrl = ALU_SLT;
                        default: alu_ctrl = ALU_ADD;
                    endcase
                end
                S_RWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 2'd1;
                end
                S_BEQ: begin
                    alu_srca = 1'b1;
                    alu_ctrl = ALU_SUB;
                    pc_src   = 2'd2;
                    PCsig    = zero;
                end
                S_IWB: begin
                    reg_write = 1'b1;
                end
                S_JUMP: begin
                    pc_src = 2'd1;
                    PCsig  = 1'b1;
                end
`ifdef MC_CTRL_JAL_JR_EN
                S_JAL: begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'd2;
                    mem_to_reg = 2'd2;
                    pc_src     = 2'd1;
                    PCsig      = 1'b1;
                end
                S_JR: begin
                    pc_src = 2'd3;
                    PCsig  = 1'b1;
                end
`endif
                S_ILL: begin
                    illegal = 1'b1;
                end
                default: begin
                    state = 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench for mc_controller with a per-instruction reference model.
module tb_mc_controller;

    typedef logic [22:0] vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instt = 32'd0;
    logic        zero = 1'b0;
    logic        PCsig, lord, IRwrite, reg_write, alu_srca;
    logic [1:0]  alu_srcb, reg_dst, mem_to_reg, pc_src;
    logic [2:0]  alu_ctrl;
    logic        mem_read, mem_write, illegal;
    logic [3:0]  state;

    int   checks = 0;
    int   errors = 0;
    int   step   = 0;
    vec_t exp_q[$];

    logic [5:0] ops [8] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02, 6'h03, 6'h3F};
    logic [5:0] fns [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h3A};

    mc_controller dut (
        .clk(clk), .rst(rst), .instt(instt), .zero(zero),
        .PCsig(PCsig), .lord(lord), .IRwrite(IRwrite), .reg_write(reg_write),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .pc_src(pc_src),
        .mem_read(mem_read), .mem_write(mem_write), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int st, bit pcs, bit lrd, bit irw, bit rw, bit sa, int sb,
                                int ac, int rd, int m2r, int ps, bit mr, bit mw, bit ill);
        return {4'(st), pcs, lrd, irw, rw, sa, 2'(sb), 3'(ac), 2'(rd), 2'(m2r), 2'(ps), mr, mw, ill};
    endfunction

    // Whole-instruction view: which named steps the instruction walks and what each drives
    function automatic void expect_seq(input logic [31:0] ins, input bit z, output vec_t q[$]);
        logic [5:0] op, fn;
        bit jal_en;
        int ac;
        op = ins[31:26];
        fn = ins[5:0];
`ifdef MC_CTRL_JAL_JR_EN
        jal_en = 1'b1;
`else
        jal_en = 1'b0;
`endif
        q = {};
        q.push_back(mk(0, 1, 0, 1, 0, 0, 1, 2, 0, 0, 0, 1, 0, 0));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 3, 2, 0, 0, 0, 0, 0, 0));
        if (op == 6'h23) begin
            q.push_back(mk(2, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0, 0, 0));
            q.push_back(mk(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
            q.push_back(mk(4, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        end else if (op == 6'h2B) begin
            q.push_back(mk(2, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0, 0, 0));
            q.push_back(mk(5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        end else if (op == 6'h00 && fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
            ac = (fn == 6'h20) ? 2 : (fn == 6'h22) ? 6 : (fn == 6'h24) ? 0 : (fn == 6'h25) ? 1 : 7;
            q.push_back(mk(6, 0, 0, 0, 0, 1, 0, ac, 0, 0, 0, 0, 0, 0));
            q.push_back(mk(7, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        end else if (op == 6'h00 && fn == 6'h08 && jal_en) begin
            q.push_back(mk(13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0));
        end else if (op == 6'h04) begin
            q.push_back(mk(8, z, 0, 0, 0, 1, 0, 6, 0, 0, 2, 0, 0, 0));
        end else if (op == 6'h08) begin
            q.push_back(mk(9, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0, 0, 0));
            q.push_back(mk(10, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end else if (op == 6'h02) begin
            q.push_back(mk(11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        end else if (op == 6'h03 && jal_en) begin
            q.push_back(mk(12, 1, 0, 0, 1, 0, 0, 0, 2, 2, 1, 0, 0, 0));
        end else begin
            q.push_back(mk(14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        end
    endfunction

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            exp_q.push_back('0);
        end
    endtask

    task automatic run_instr(input logic [31:0] ins, input bit z, input int maxc);
        vec_t q[$];
        expect_seq(ins, z, q);
        for (int k = 0; k < q.size() && k < maxc; k++) begin
            @(negedge clk);
            rst   = 1'b0;
            instt = ins;
            zero  = z;
            exp_q.push_back(q[k]);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        r[31:26] = ops[$urandom_range(0, 7)];
        if (r[31:26] == 6'h00) r[5:0] = fns[$urandom_range(0, 6)];
        if ($urandom_range(0, 9) == 0) r[31:26] = 6'($urandom);
        return r;
    endfunction

    // Monitor: every cycle the DUT presents a control vector; compare with the oldest expectation
    initial begin
        vec_t e, a;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {state, PCsig, lord, IRwrite, reg_write, alu_srca, alu_srcb, alu_ctrl,
                     reg_dst, mem_to_reg, pc_src, mem_read, mem_write, illegal};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL ctrl_vec step=%0d got=%h (state %0d) exp=%h (state %0d)",
                             step, a, a[22:19], e, e[22:19]);
                end
                step++;
            end
        end
    end

    initial begin
        do_reset(3);
        run_instr(32'h8C220004, 1'b0, 99);
        run_instr(32'hAC220004, 1'b0, 99);
        run_instr(32'h10220003, 1'b1, 99);
        run_instr(32'h10220003, 1'b0, 99);
        run_instr(32'h0022182A, 1'b0, 99);
        run_instr(32'hFC000000, 1'b0, 99);
        run_instr(32'h0C000010, 1'b0, 99);
        run_instr(32'h03E00008, 1'b1, 99);
        run_instr(32'h20420005, 1'b0, 99);
        run_instr(32'h08000004, 1'b0, 99);
        run_instr(32'h8C220004, 1'b0, 3);
        do_reset(2);
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                run_instr(rand_instr(), 1'($urandom), $urandom_range(1, 4));
                do_reset($urandom_range(1, 2));
            end else begin
                run_instr(rand_instr(), 1'($urandom), 99);
            end
        end
        @(negedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
